mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the KCP53K cpu2 pipeline; sits downstream of decode/execute and consumes their `nomem`/`mem`/`we`/`dat`/`xrs_rwe`/`rd` controls plus the ALU result as effective address.
- Pass-through ops forward the ALU result to writeback.
- Loads and stores run one classic Wishbone B4 master cycle on a 64-bit data bus.
- Load data is lane-selected and sign- or zero-extended; results and writeback controls go to the register-file write port.

Parameters:
- ADR_W, 64, width of `wb_adr_o`; driven from `addr_i[ADR_W-1:0]`.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_i  in  1  reset, asynchronous, active-low.
- valid_i  in  1  upstream op present this cycle.
- addr_i  in  64  ALU result / effective address.
- dat_i  in  64  store data (rs2 value).
- rd_i  in  5  destination register.
- we_i  in  1  store op.
- mem_i  in  1  load op.
- nomem_i  in  1  non-memory op; `addr_i` is the result.
- xrs_rwe_i  in  3  access size/sign: 0=S8, 1=S16, 2=S32, 3=S64, 4=U8, 5=U16, 6=U32, 7=reserved (treated as S64).
- stall_o  out  1  high while a bus cycle is pending; upstream holds its op.
- valid_o  out  1  one-cycle completion strobe.
- rd_o  out  5  destination register of the completed op.
- res_o  out  64  writeback value.
- rwe_o  out  1  register write enable, qualified by `valid_o`.
- misalign_o  out  1  completed op was a misaligned access.
- bus_err_o  out  1  completed op was terminated by `wb_err_i`.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone cycle, strobe, write.
- wb_adr_o  out  ADR_W  byte address, `addr_i` unmodified.
- wb_sel_o  out  8  byte-lane selects.
- wb_dat_o  out  64  write data.
- wb_ack_i, wb_err_i  in  1 each  Wishbone termination.
- wb_dat_i  in  64  read data.

Behaviour:
- Reset (`reset_i`=0, async):
  - State goes to IDLE.
  - All outputs go to 0, including `wb_cyc_o`/`wb_stb_o` immediately, even mid-cycle; the pending op is discarded with no `valid_o`.
- Op class, priority when several are set: `we_i` > `mem_i` > `nomem_i`. `valid_i`=1 with none set is a bubble: no output.
- Acceptance: at a rising edge with state IDLE and `valid_i`=1. Inputs offered while `stall_o`=1 are ignored.
- nomem op, accepted at edge N:
  - Cycle after N: `valid_o`=1, `res_o`=`addr_i`, `rd_o`=`rd_i`, `rwe_o`=(`rd_i`!=0).
  - Back-to-back nomem ops run at one per cycle with no stall.
- Alignment check at acceptance:
  - 16-bit: `addr[0]` must be 0.
  - 32-bit: `addr[1:0]` must be 0.
  - 64-bit: `addr[2:0]` must be 0.
  - Misaligned op: no bus cycle; next cycle `valid_o`=1, `misalign_o`=1, `rwe_o`=0.
- Aligned mem op, accepted at edge N:
  - State goes to BUS; `wb_cyc_o`=`wb_stb_o`=1 and `stall_o`=1 from N.
  - `wb_sel_o` = size mask (0x01/0x03/0x0F/0xFF) shifted left by `addr[2:0]`.
  - Store: `wb_we_o`=1; `wb_dat_o` = low `size` bytes of `dat_i` replicated across all lanes.
  - Load: `wb_we_o`=0, `wb_dat_o`=0.
  - Address, sel and data stay stable until termination.
- Termination at edge N+k (`wb_ack_i` or `wb_err_i` sampled high, k≥1):
  - `wb_cyc_o`, `wb_stb_o`, `stall_o` all 0 after that edge; state goes to IDLE.
  - `valid_o`=1 for one cycle; a new op can be accepted at edge N+k+1.
  - Minimum memory-op occupancy is 2 cycles.
- Load result: `wb_dat_i` shifted right by 8×`addr[2:0]`, truncated to size, then sign-extended (S) or zero-extended (U). `rwe_o`=(`rd_i`!=0).
- Store result: `rwe_o`=0, `res_o`=0.
- `wb_err_i`: wins if high together with `wb_ack_i`. Gives `bus_err_o`=1, `rwe_o`=0, `res_o`=0.
- Idle behaviour: `valid_o`, `misalign_o`, `bus_err_o` are 0 whenever no completion occurs; `res_o`/`rd_o` hold their last values.
- `wb_ack_i`/`wb_err_i` received outside BUS are ignored.

Test Plan:
1. Reset low mid-load with `wb_cyc_o`=1 → `wb_cyc_o`/`wb_stb_o`/`stall_o`/`valid_o` drop to 0 asynchronously; after release, a nomem op with `addr`=5, `rd`=1 gives `valid_o`=1, `res_o`=5, `rwe_o`=1 one cycle later.
2. Load U8 at `addr`=0x1003, `wb_dat_i`=0x0011_2233_4455_66F7, ack after 2 wait cycles → `wb_sel_o`=0x08, `stall_o` high 3 cycles, `res_o`=0x44, `rwe_o`=1. Same op with S8 at `addr`=0x1000 → `res_o`=0xFFFF_FFFF_FFFF_FFF7.
3. Store S16 `dat_i`=0xDEAD_BEEF_FEED_FACE at `addr`=0x2006 → `wb_we_o`=1, `wb_sel_o`=0xC0, `wb_dat_o`=0xFACE_FACE_FACE_FACE; on ack `valid_o`=1, `rwe_o`=0.
4. Load S32 at `addr`=0x3002 → no `wb_cyc_o`; next cycle `valid_o`=1, `misalign_o`=1, `rwe_o`=0.
5. Load S64 with `wb_err_i` and `wb_ack_i` both high at termination → `bus_err_o`=1, `rwe_o`=0, `res_o`=0; second op held during the stall is accepted the edge after termination.
6. Three back-to-back nomem ops with `rd`=0, 2, 3 → `valid_o` high 3 consecutive cycles, `stall_o`=0 throughout, `rwe_o` = 0, 1, 1.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: forwards ALU results, runs one classic Wishbone B4 cycle per
// load/store, and lane-selects and extends load data for the register-file write port.
module mem_stage #(
    parameter int ADR_W = 64
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             valid_i,
    input  logic [63:0]      addr_i,
    input  logic [63:0]      dat_i,
    input  logic [4:0]       rd_i,
    input  logic             we_i,
    input  logic             mem_i,
    input  logic             nomem_i,
    input  logic [2:0]       xrs_rwe_i,
    output logic             stall_o,
    output logic             valid_o,
    output logic [4:0]       rd_o,
    output logic [63:0]      res_o,
    output logic             rwe_o,
    output logic             misalign_o,
    output logic             bus_err_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [ADR_W-1:0] wb_adr_o,
    output logic [7:0]       wb_sel_o,
    output logic [63:0]      wb_dat_o,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    input  logic [63:0]      wb_dat_i
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic             we_q, we_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [7:0]       sel_q, sel_d;
    logic [63:0]      wdat_q, wdat_d;
    logic [2:0]       lane_q, lane_d;
    logic [1:0]       size_q, size_d;
    logic             sign_q, sign_d;
    logic [4:0]       rd_pend_q, rd_pend_d;

    logic             valid_q, valid_d;
    logic [4:0]       rd_out_q, rd_out_d;
    logic [63:0]      res_q, res_d;
    logic             rwe_q, rwe_d;
    logic             mis_q, mis_d;
    logic             berr_q, berr_d;

    // Decode of the incoming access: size as log2(bytes), signedness, alignment.
    logic [1:0]  size_c;
    logic        sign_c;
    logic        misaligned_c;
    logic [7:0]  sel_c;
    logic [63:0] repl_c;

    always_comb begin
        size_c       = (xrs_rwe_i == 3'd7) ? 2'd3 : xrs_rwe_i[1:0];
        sign_c       = !xrs_rwe_i[2] || (xrs_rwe_i == 3'd7);
        misaligned_c = 1'b0;
        sel_c        = 8'h00;
        repl_c       = 64'd0;
        case (size_c)
            2'd0: begin
                sel_c  = 8'h01 << addr_i[2:0];
                repl_c = {8{dat_i[7:0]}};
            end
            2'd1: begin
                misaligned_c = addr_i[0];
                sel_c        = 8'h03 << addr_i[2:0];
                repl_c       = {4{dat_i[15:0]}};
            end
            2'd2: begin
                misaligned_c = |addr_i[1:0];
                sel_c        = 8'h0F << addr_i[2:0];
                repl_c       = {2{dat_i[31:0]}};
            end
            default: begin
                misaligned_c = |addr_i[2:0];
                sel_c        = 8'hFF << addr_i[2:0];
                repl_c       = dat_i;
            end
        endcase
    end

    // Load data: bring the addressed lane down to bit 0, then truncate and extend.
    logic [63:0] shifted_c;
    logic [63:0] load_val_c;

    always_comb begin
        shifted_c  = wb_dat_i >> {lane_q, 3'b000};
        load_val_c = shifted_c;
        case (size_q)
            2'd0:    load_val_c = sign_q ? {{56{shifted_c[7]}}, shifted_c[7:0]}
                                         : {56'd0, shifted_c[7:0]};
            2'd1:    load_val_c = sign_q ? {{48{shifted_c[15]}}, shifted_c[15:0]}
                                         : {48'd0, shifted_c[15:0]};
            2'd2:    load_val_c = sign_q ? {{32{shifted_c[31]}}, shifted_c[31:0]}
                                         : {32'd0, shifted_c[31:0]};
            default: load_val_c = shifted_c;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            adr_q     <= '0;
            sel_q     <= 8'h00;
            wdat_q    <= 64'd0;
            lane_q    <= 3'd0;
            size_q    <= 2'd0;
            sign_q    <= 1'b0;
            rd_pend_q <= 5'd0;
            valid_q   <= 1'b0;
            rd_out_q  <= 5'd0;
            res_q     <= 64'd0;
            rwe_q     <= 1'b0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            sel_q     <= sel_d;
            wdat_q    <= wdat_d;
            lane_q    <= lane_d;
            size_q    <= size_d;
            sign_q    <= sign_d;
            rd_pend_q <= rd_pend_d;
            valid_q   <= valid_d;
            rd_out_q  <= rd_out_d;
            res_q     <= res_d;
            rwe_q     <= rwe_d;
            mis_q     <= mis_d;
            berr_q    <= berr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        sel_d     = sel_q;
        wdat_d    = wdat_q;
        lane_d    = lane_q;
        size_d    = size_q;
        sign_d    = sign_q;
        rd_pend_d = rd_pend_q;
        valid_d   = 1'b0;
        rd_out_d  = rd_out_q;
        res_d     = res_q;
        rwe_d     = 1'b0;
        mis_d     = 1'b0;
        berr_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    if (we_i || mem_i) begin
                        if (misaligned_c) begin
                            valid_d  = 1'b1;
                            mis_d    = 1'b1;
                            rd_out_d = rd_i;
                            res_d    = 64'd0;
                        end else begin
                            state_d   = S_BUS;
                            we_d      = we_i;
                            adr_d     = addr_i[ADR_W-1:0];
                            sel_d     = sel_c;
                            wdat_d    = we_i ? repl_c : 64'd0;
                            lane_d    = addr_i[2:0];
                            size_d    = size_c;
                            sign_d    = sign_c;
                            rd_pend_d = rd_i;
                        end
                    end else if (nomem_i) begin
                        valid_d  = 1'b1;
                        rd_out_d = rd_i;
                        res_d    = addr_i;
                        rwe_d    = |rd_i;
                    end
                end
            end
            S_BUS: begin
                // Error termination takes precedence over a simultaneous ack.
                if (wb_ack_i || wb_err_i) begin
                    state_d  = S_IDLE;
                    valid_d  = 1'b1;
                    rd_out_d = rd_pend_q;
                    we_d     = 1'b0;
                    sel_d    = 8'h00;
                    wdat_d   = 64'd0;
                    if (wb_err_i) begin
                        berr_d = 1'b1;
                        res_d  = 64'd0;
                    end else if (we_q) begin
                        res_d = 64'd0;
                    end else begin
                        res_d = load_val_c;
                        rwe_d = |rd_pend_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign stall_o    = (state_q == S_BUS);
    assign wb_cyc_o   = (state_q == S_BUS);
    assign wb_stb_o   = (state_q == S_BUS);
    assign wb_we_o    = we_q;
    assign wb_adr_o   = adr_q;
    assign wb_sel_o   = sel_q;
    assign wb_dat_o   = wdat_q;
    assign valid_o    = valid_q;
    assign rd_o       = rd_out_q;
    assign res_o      = res_q;
    assign rwe_o      = rwe_q;
    assign misalign_o = mis_q;
    assign bus_err_o  = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected completions, a monitor
// pops and compares them (including completion cycle) whenever valid_o is seen.
module tb_mem_stage;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [63:0] addr_i = 64'd0;
    logic [63:0] dat_i = 64'd0;
    logic [4:0]  rd_i = 5'd0;
    logic        we_i = 1'b0;
    logic        mem_i = 1'b0;
    logic        nomem_i = 1'b0;
    logic [2:0]  xrs_rwe_i = 3'd0;
    logic        stall_o, valid_o, rwe_o, misalign_o, bus_err_o;
    logic [4:0]  rd_o;
    logic [63:0] res_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [63:0] wb_adr_o;
    logic [7:0]  wb_sel_o;
    logic [63:0] wb_dat_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic [63:0] wb_dat_i = 64'd0;

    mem_stage #(.ADR_W(64)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .addr_i(addr_i),
        .dat_i(dat_i), .rd_i(rd_i), .we_i(we_i), .mem_i(mem_i), .nomem_i(nomem_i),
        .xrs_rwe_i(xrs_rwe_i), .stall_o(stall_o), .valid_o(valid_o), .rd_o(rd_o),
        .res_o(res_o), .rwe_o(rwe_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we, mem, nomem;
        logic [2:0]  code;
        logic [63:0] addr, dat;
        logic [4:0]  rd;
    } op_t;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] res;
        logic        rwe, mis, berr, full;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    op_t  none;

    always @(posedge clk_i) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int nbytes_of(input logic [2:0] c);
        case (c)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2, 3'd6: return 4;
            default:    return 8;
        endcase
    endfunction

    function automatic bit is_signed(input logic [2:0] c);
        return (c < 3'd4) || (c == 3'd7);
    endfunction

    function automatic bit is_aligned(input logic [63:0] a, input logic [2:0] c);
        int lo = int'(a[2:0]);
        return (lo % nbytes_of(c)) == 0;
    endfunction

    // Little-endian byte gather from the addressed lane, then extension.
    function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [63:0] a,
                                               input logic [2:0] c);
        int n = nbytes_of(c);
        int lane = int'(a[2:0]);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(lane+i) +: 8];
        if (is_signed(c) && v[8*n-1])
            for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] model_sel(input logic [63:0] a, input logic [2:0] c);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < nbytes_of(c); i++) s[int'(a[2:0]) + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [63:0] d, input logic [2:0] c);
        logic [63:0] w = 64'd0;
        for (int j = 0; j < 8; j++) w[8*j +: 8] = d[8*(j % nbytes_of(c)) +: 8];
        return w;
    endfunction

    task automatic drive(input op_t o);
        we_i      = o.we;
        mem_i     = o.mem;
        nomem_i   = o.nomem;
        xrs_rwe_i = o.code;
        addr_i    = o.addr;
        dat_i     = o.dat;
        rd_i      = o.rd;
    endtask

    // Issue one op at posedge+1 and, for bus ops, play the Wishbone slave.
    task automatic applyStimulus(input op_t o, input int waits, input logic err, input logic ack,
                                 input logic [63:0] rdata, input logic hold_en, input op_t held);
        exp_t e;
        bit   memop, bubble, aligned;
        int   stall_seen;
        memop   = o.we || o.mem;
        bubble  = !memop && !o.nomem;
        aligned = is_aligned(o.addr, o.code);
        drive(o);
        valid_i = 1'b1;
        e.rd = o.rd; e.res = 64'd0; e.rwe = 1'b0; e.mis = 1'b0; e.berr = 1'b0; e.full = 1'b1;
        if (memop && !aligned) begin
            e.mis = 1'b1; e.full = 1'b0; e.cyc = cycle + 1;
        end else if (memop) begin
            e.cyc = cycle + 2 + waits;
            if (err) e.berr = 1'b1;
            else if (!o.we) begin
                e.res = model_load(rdata, o.addr, o.code);
                e.rwe = (o.rd != 5'd0);
            end
        end else begin
            e.res = o.addr; e.rwe = (o.rd != 5'd0); e.cyc = cycle + 1;
        end
        if (!bubble) exp_q.push_back(e);
        if (!(memop && aligned)) wb_ack_i = 1'($urandom_range(0, 1));
        @(posedge clk_i); #1;
        wb_ack_i = 1'b0;
        if (memop && aligned) begin
            checkOutput("wb_cyc_o", wb_cyc_o, 1);
            checkOutput("wb_stb_o", wb_stb_o, 1);
            checkOutput("wb_we_o", wb_we_o, o.we);
            checkOutput("wb_adr_o", wb_adr_o, o.addr);
            checkOutput("wb_sel_o", wb_sel_o, model_sel(o.addr, o.code));
            checkOutput("wb_dat_o", wb_dat_o, o.we ? model_wdata(o.dat, o.code) : 64'd0);
            if (hold_en) begin
                drive(held);
                valid_i = 1'b1;
            end else valid_i = 1'b0;
            stall_seen = int'(stall_o);
            repeat (waits) begin
                @(posedge clk_i); #1;
                stall_seen += int'(stall_o);
                checkOutput("wb_sel_hold", wb_sel_o, model_sel(o.addr, o.code));
            end
            wb_dat_i = rdata;
            if (err) begin
                wb_err_i = 1'b1; wb_ack_i = ack;
            end else wb_ack_i = 1'b1;
            @(posedge clk_i); #1;
            wb_ack_i = 1'b0; wb_err_i = 1'b0;
            wb_dat_i = {$urandom, $urandom};
            checkOutput("stall_cycles", stall_seen, waits + 1);
            checkOutput("wb_cyc_end", wb_cyc_o, 0);
            checkOutput("stall_end", stall_o, 0);
        end else begin
            valid_i = 1'b0;
            checkOutput("no_bus_cyc", wb_cyc_o, 0);
            checkOutput("no_stall", stall_o, 0);
        end
    endtask

    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (reset_i) begin
            if (valid_o) begin
                if (exp_q.size() == 0) checkOutput("unexpected_valid", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    checkOutput("valid_cycle", cycle, e.cyc);
                    checkOutput("misalign_o", misalign_o, e.mis);
                    checkOutput("bus_err_o", bus_err_o, e.berr);
                    checkOutput("rwe_o", rwe_o, e.rwe);
                    if (e.full) begin
                        checkOutput("rd_o", rd_o, e.rd);
                        checkOutput("res_o", res_o, e.res);
                    end
                end
            end else checkOutput("idle_flags", {misalign_o, bus_err_o, rwe_o}, 3'b000);
        end
    end

    function automatic op_t mk(input logic we, input logic mem, input logic nomem,
                               input logic [2:0] code, input logic [63:0] addr,
                               input logic [63:0] dat, input logic [4:0] rd);
        op_t o;
        o.we = we; o.mem = mem; o.nomem = nomem; o.code = code;
        o.addr = addr; o.dat = dat; o.rd = rd;
        return o;
    endfunction

    initial begin
        op_t o, h;
        int  k, n, lo;
        none = mk(0, 0, 0, 3'd0, 64'd0, 64'd0, 5'd0);

        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("reset_outputs", {stall_o, valid_o, wb_cyc_o, wb_stb_o, rwe_o, wb_we_o},
                    6'b000000);
        checkOutput("reset_res_o", res_o, 64'd0);
        checkOutput("reset_sel", {wb_sel_o, 3'b000, rd_o}, 16'h0000);
        reset_i = 1'b1;
        @(posedge clk_i); #1;

        // Reset asserted in the middle of a load cycle.
        drive(mk(0, 1, 0, 3'd3, 64'h8, 64'd0, 5'd6));
        valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        checkOutput("pre_reset_cyc", wb_cyc_o, 1);
        #2 reset_i = 1'b0;
        #1;
        checkOutput("async_reset", {wb_cyc_o, wb_stb_o, stall_o, valid_o}, 4'b0000);
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        applyStimulus(mk(0, 0, 1, 3'd0, 64'd5, 64'd0, 5'd1), 0, 0, 0, 0, 0, none);

        applyStimulus(mk(0, 1, 0, 3'd4, 64'h1003, 64'd0, 5'd4), 2, 0, 0,
                      64'h0011_2233_4455_66F7, 0, none);
        applyStimulus(mk(0, 1, 0, 3'd0, 64'h1000, 64'd0, 5'd4), 1, 0, 0,
                      64'h0011_2233_4455_66F7, 0, none);
        applyStimulus(mk(1, 0, 0, 3'd1, 64'h2006, 64'hDEAD_BEEF_FEED_FACE, 5'd9), 0, 0, 0,
                      64'd0, 0, none);
        applyStimulus(mk(0, 1, 0, 3'd2, 64'h3002, 64'd0, 5'd8), 0, 0, 0, 64'd0, 0, none);

        h = mk(0, 0, 1, 3'd0, 64'h77, 64'd0, 5'd7);
        applyStimulus(mk(0, 1, 0, 3'd3, 64'h4000, 64'd0, 5'd10), 1, 1, 1,
                      64'h1234_5678_9ABC_DEF0, 1, h);
        applyStimulus(h, 0, 0, 0, 64'd0, 0, none);

        applyStimulus(mk(0, 0, 1, 3'd0, 64'hA0, 64'd0, 5'd0), 0, 0, 0, 64'd0, 0, none);
        applyStimulus(mk(0, 0, 1, 3'd0, 64'hA1, 64'd0, 5'd2), 0, 0, 0, 64'd0, 0, none);
        applyStimulus(mk(0, 0, 1, 3'd0, 64'hA2, 64'd0, 5'd3), 0, 0, 0, 64'd0, 0, none);

        for (int it = 0; it < 300; it++) begin
            k = $urandom_range(0, 9);
            o.code = 3'($urandom_range(0, 7));
            o.addr = {$urandom, $urandom};
            o.dat  = {$urandom, $urandom};
            o.rd   = 5'($urandom_range(0, 31));
            o.we    = (k <= 2);
            o.mem   = (k <= 2) ? 1'($urandom_range(0, 1)) : (k <= 5);
            o.nomem = (k <= 5) ? 1'($urandom_range(0, 1)) : (k <= 8);
            n = nbytes_of(o.code);
            if ($urandom_range(0, 3) != 0) begin
                lo = int'(o.addr[2:0]);
                o.addr[2:0] = 3'(lo - (lo % n));
            end
            applyStimulus(o, $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                          1'($urandom_range(0, 1)), {$urandom, $urandom}, 0, none);
        end

        repeat (4) @(posedge clk_i);
        #1;
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
